rtc_alarm_sched: RTL and testbench

Multi-slot alarm scheduler for the RTC core, in the APB clock domain next to the interrupt controller. On each once-per-second time update it scans N alarm slots against the current calendar time. It latches a pending flag for every slot that matches. Pending alarms are presented one at a time on a single request/acknowledge interrupt, and the slot to present is chosen round-robin.

---
 rtl/rtc_alarm_sched.sv | 186 ++++++++++++++++++
 tb/tb_rtc_alarm_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_sched.sv
// rtc_alarm_sched: scans N alarm slots on each one-second time update, latches
// a pending flag per matching slot and presents pending alarms one at a time
// on a request/acknowledge interrupt, chosen round-robin.
// Optional feature macro: RTC_ALARM_ONESHOT_EN (acknowledge also disables the slot).
module rtc_alarm_sched #(
  parameter  int N_ALARMS = 4,
  localparam int IW       = $clog2(N_ALARMS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [37:0]         cur_time_i,
  input  logic                cfg_we_i,
  input  logic [IW-1:0]       cfg_idx_i,
  input  logic                cfg_en_i,
  input  logic [7:0]          cfg_mask_i,
  input  logic [37:0]         cfg_time_i,
  input  logic                ir_ack_i,
  output logic                ir_o,
  output logic [IW-1:0]       ir_id_o,
  output logic [N_ALARMS-1:0] pending_o,
  output logic [N_ALARMS-1:0] en_o,
  output logic                busy_o,
  output logic                missed_o,
  input  logic                clr_missed_i
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_IRQ, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       ir_id_q, ir_id_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic                tick_pend_q, tick_pend_d;
  logic                missed_q, missed_d;
  logic [N_ALARMS-1:0] pending_q, pending_d;

  logic                en_q   [N_ALARMS];
  logic [7:0]          mask_q [N_ALARMS];
  logic [37:0]         time_q [N_ALARMS];

  logic                scan_hit;
  logic                grant_found;
  logic [IW-1:0]       grant_idx;
  logic [IW-1:0]       cand;
  logic                write_cur;
  logic                ack_take;

  // Expand the 8-bit field mask into a per-bit care mask over the packed time.
  function automatic logic [37:0] care_bits(input logic [7:0] m);
    care_bits = {{7{m[7]}}, {4{m[6]}}, {5{m[5]}}, {3{m[4]}},
                 {2{m[3]}}, {5{m[2]}}, {6{m[1]}}, {6{m[0]}}};
  endfunction

  // Compare of the slot currently addressed by the scan index.
  assign scan_hit = en_q[idx_q] & (|mask_q[idx_q]) &
                    ~(|((cur_time_i ^ time_q[idx_q]) & care_bits(mask_q[idx_q])));

  // A config write to the presented slot withdraws it; otherwise ack retires it.
  assign write_cur = cfg_we_i & (cfg_idx_i == ir_id_q);
  assign ack_take  = (state_q == S_IRQ) & ir_ack_i & ~write_cur;

  // Round-robin pick: first pending slot searching upward from last_grant+1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_ALARMS; i++) begin
      cand = IW'((int'(last_grant_q) + i) % N_ALARMS);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic for the scan/arbitration FSM and its bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ir_id_d      = ir_id_q;
    last_grant_d = last_grant_q;
    tick_pend_d  = tick_pend_q;
    missed_d     = missed_q & ~clr_missed_i;
    pending_d    = pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (tick_i || tick_pend_q) begin
          // A fresh tick while one is already queued can only be absorbed once.
          if (tick_i && tick_pend_q) missed_d = 1'b1;
          state_d     = S_SCAN;
          idx_d       = '0;
          tick_pend_d = 1'b0;
        end else if (grant_found) begin
          state_d = S_IRQ;
          ir_id_d = grant_idx;
        end
      end
      S_SCAN: begin
        if (scan_hit) pending_d[idx_q] = 1'b1;
        if (tick_i)   missed_d         = 1'b1;
        if (idx_q == IW'(N_ALARMS - 1)) state_d = S_IDLE;
        else                            idx_d   = idx_q + IW'(1);
      end
      S_IRQ, S_GAP: begin
        if (tick_i) begin
          if (tick_pend_q) missed_d    = 1'b1;
          else             tick_pend_d = 1'b1;
        end
        if (state_q == S_GAP) begin
          state_d = S_IDLE;
        end else if (write_cur) begin
          state_d = S_GAP;
        end else if (ack_take) begin
          pending_d[ir_id_q] = 1'b0;
          last_grant_d       = ir_id_q;
          state_d            = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any rewrite of a slot discards whatever it had pending.
    if (cfg_we_i && (int'(cfg_idx_i) < N_ALARMS)) pending_d[cfg_idx_i] = 1'b0;
  end

  // FSM and status registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ir_id_q      <= '0;
      last_grant_q <= IW'(N_ALARMS - 1);
      tick_pend_q  <= 1'b0;
      missed_q     <= 1'b0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ir_id_q      <= ir_id_d;
      last_grant_q <= last_grant_d;
      tick_pend_q  <= tick_pend_d;
      missed_q     <= missed_d;
      pending_q    <= pending_d;
    end
  end

  // Slot configuration registers; a write wins over the one-shot disable.
  always_ff @(posedge clk_i) begin
    // NOTE: the slot array is small and software reads en_o right after reset, so it is reset explicitly.
    if (rst_i) begin
      for (int k = 0; k < N_ALARMS; k++) begin
        en_q[k]   <= 1'b0;
        mask_q[k] <= '0;
        time_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_ALARMS; k++) begin
        if (cfg_we_i && (cfg_idx_i == IW'(k))) begin
          en_q[k]   <= cfg_en_i;
          mask_q[k] <= cfg_mask_i;
          time_q[k] <= cfg_time_i;
        end
`ifdef RTC_ALARM_ONESHOT_EN
        else if (ack_take && (ir_id_q == IW'(k))) begin
          en_q[k] <= 1'b0;
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_en
    assign en_o[g] = en_q[g];
  end

  assign ir_o      = (state_q == S_IRQ);
  assign ir_id_o   = ir_id_q;
  assign pending_o = pending_q;
  assign busy_o    = (state_q != S_IDLE);
  assign missed_o  = missed_q;

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// Testbench for rtc_alarm_sched: directed scenarios followed by randomized
// slot configurations, all checked against a field-level reference model.
module tb_rtc_alarm_sched;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_i, tick_i, cfg_we_i, cfg_en_i, ir_ack_i, clr_missed_i;
  logic [37:0]   cur_time_i, cfg_time_i;
  logic [IW-1:0] cfg_idx_i;
  logic [7:0]    cfg_mask_i;
  logic          ir_o, busy_o, missed_o;
  logic [IW-1:0] ir_id_o;
  logic [N-1:0]  pending_o, en_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: slot contents and the last granted slot.
  bit          m_en   [N];
  logic [7:0]  m_mask [N];
  logic [37:0] m_time [N];
  int          m_last;

  rtc_alarm_sched #(.N_ALARMS(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .cur_time_i(cur_time_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_mask_i(cfg_mask_i), .cfg_time_i(cfg_time_i), .ir_ack_i(ir_ack_i),
    .ir_o(ir_o), .ir_id_o(ir_id_o), .pending_o(pending_o), .en_o(en_o),
    .busy_o(busy_o), .missed_o(missed_o), .clr_missed_i(clr_missed_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_en[k] = 1'b0; m_mask[k] = '0; m_time[k] = '0;
    end
    m_last = N - 1;
  endfunction

  // Field-by-field comparison using field offsets and widths of the packed time.
  function automatic bit slot_match(input int k, input logic [37:0] cur);
    int lo [8] = '{0, 6, 12, 17, 19, 22, 27, 31};
    int w  [8] = '{6, 6, 5, 2, 3, 5, 4, 7};
    longint unsigned a, b;
    if (!m_en[k] || m_mask[k] == 8'h00) return 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (((m_mask[k] >> f) & 8'h01) != 8'h00) begin
        a = 64'(cur);
        b = 64'(m_time[k]);
        a = (a >> lo[f]) % (64'd1 << w[f]);
        b = (b >> lo[f]) % (64'd1 << w[f]);
        if (a != b) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] exp_set(input logic [37:0] cur);
    logic [N-1:0] s = '0;
    for (int k = 0; k < N; k++)
      if (slot_match(k, cur)) s |= (N'(1) << k);
    return s;
  endfunction

  function automatic int pick(input logic [N-1:0] set, input int last);
    for (int i = 1; i <= N; i++) begin
      int j = (last + i) % N;
      if (((set >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic cfg_write(input int k, input bit en, input logic [7:0] mask, input logic [37:0] t);
    cfg_idx_i = IW'(k); cfg_en_i = en; cfg_mask_i = mask; cfg_time_i = t; cfg_we_i = 1'b1;
    m_en[k] = en; m_mask[k] = mask; m_time[k] = t;
    step(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic do_tick(input logic [37:0] t);
    cur_time_i = t; tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
  endtask

  // Entered in an IRQ cycle; leaves three cycles after the acknowledge.
  task automatic serve(input int id, input int dly);
    check("irq_req", 64'(ir_o), 64'd1);
    check("irq_id", 64'(ir_id_o), 64'(id));
    repeat (dly) begin
      step(1);
      check("irq_hold", 64'(ir_o), 64'd1);
    end
    ir_ack_i = 1'b1;
    step(1);
    ir_ack_i = 1'b0;
    m_last = id;
`ifdef RTC_ALARM_ONESHOT_EN
    m_en[id] = 1'b0;
`endif
    check("gap_irq_low", 64'(ir_o), 64'd0);
    check("gap_pend_clr", 64'((pending_o >> id) & N'(1)), 64'd0);
    check("en_after_ack", 64'((en_o >> id) & N'(1)), 64'(m_en[id]));
    step(2);
  endtask

  // Entered at first-IRQ time after a scan; serves the whole expected set.
  task automatic serve_all(input logic [N-1:0] set, input bit rnd_dly);
    int id;
    check("pend_set", 64'(pending_o), 64'(set));
    check("irq_any", 64'(ir_o), 64'(set != '0));
    for (int n = 0; n < N && set != '0; n++) begin
      id = pick(set, m_last);
      serve(id, rnd_dly ? int'($urandom_range(0, 2)) : 0);
      set &= ~(N'(1) << id);
    end
    check("drained", 64'(ir_o), 64'd0);
  endtask

  initial begin
    logic [37:0] cur, t;
    logic [63:0] r;
    logic [7:0]  mk;

    rst_i = 1'b1; tick_i = 1'b0; cfg_we_i = 1'b0; cfg_en_i = 1'b0; ir_ack_i = 1'b0;
    clr_missed_i = 1'b0; cur_time_i = '0; cfg_time_i = '0; cfg_idx_i = '0; cfg_mask_i = '0;
    model_reset();
    step(2);
    rst_i = 1'b0;

    // Reset state.
    check("rst_ir", 64'(ir_o), 64'd0);
    check("rst_id", 64'(ir_id_o), 64'd0);
    check("rst_pend", 64'(pending_o), 64'd0);
    check("rst_en", 64'(en_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_missed", 64'(missed_o), 64'd0);

    // Single slot, seconds only.
    cfg_write(0, 1'b1, 8'h01, 38'd30);
    check("en0_set", 64'(en_o), 64'b0001);
    do_tick(38'd29);
    step(N + 1);
    check("sec29_pend", 64'(pending_o), 64'd0);
    check("sec29_ir", 64'(ir_o), 64'd0);
    do_tick(38'd30);
    check("sec30_t1", 64'(pending_o), 64'd0);
    step(1);
    check("sec30_t2", 64'(pending_o), 64'(exp_set(38'd30)));
    step(3);
    check("sec30_t5_ir", 64'(ir_o), 64'd0);
    step(1);
    serve(0, 0);
    check("after_ack_ir", 64'(ir_o), 64'd0);

    // Periodic vs one-shot behaviour.
    do_tick(38'd30);
    step(5);
    serve_all(exp_set(38'd30), 1'b0);

    // Round-robin among slots 1..3.
    cur = 38'd5 << 6;
    cfg_write(0, 1'b0, 8'h00, '0);
    for (int k = 1; k < N; k++) cfg_write(k, 1'b1, 8'h02, cur);
    do_tick(cur);
    step(5);
    serve_all(exp_set(cur), 1'b0);
    cfg_write(2, 1'b1, 8'h02, 38'd6 << 6);
    cfg_write(1, 1'b1, 8'h02, cur);
    cfg_write(3, 1'b1, 8'h02, cur);
    do_tick(cur);
    step(5);
    serve_all(exp_set(cur), 1'b0);

    // Tick during IRQ is queued, not missed.
    cfg_write(2, 1'b0, 8'h02, cur);
    cfg_write(3, 1'b0, 8'h02, cur);
    cfg_write(1, 1'b1, 8'h02, cur);
    do_tick(cur);
    step(5);
    check("tirq_req", 64'(ir_o), 64'd1);
    check("tirq_id", 64'(ir_id_o), 64'd1);
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    check("tirq_still", 64'(ir_o), 64'd1);
    ir_ack_i = 1'b1;
    step(1);
    ir_ack_i = 1'b0;
    m_last = 1;
`ifdef RTC_ALARM_ONESHOT_EN
    m_en[1] = 1'b0;
`endif
    check("tirq_gap", 64'(ir_o), 64'd0);
    step(2);
    check("tirq_rescan", 64'(busy_o), 64'd1);
    check("tirq_nomiss", 64'(missed_o), 64'd0);
    step(5);
    serve_all(exp_set(cur), 1'b0);

    // Tick during SCAN is dropped and flagged.
    cfg_write(1, 1'b1, 8'h02, cur);
    do_tick(cur);
    step(1);
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    check("scan_missed", 64'(missed_o), 64'd1);
    clr_missed_i = 1'b1;
    step(1);
    clr_missed_i = 1'b0;
    check("clr_missed", 64'(missed_o), 64'd0);
    step(2);
    serve_all(exp_set(cur), 1'b0);

    // Rewriting the presented slot withdraws the request.
    cfg_write(1, 1'b0, 8'h02, cur);
    cfg_write(2, 1'b1, 8'h02, cur);
    do_tick(cur);
    step(5);
    check("wirq_req", 64'(ir_o), 64'd1);
    check("wirq_id", 64'(ir_id_o), 64'(pick(exp_set(cur), m_last)));
    cfg_write(2, 1'b1, 8'h02, cur);
    check("wirq_drop", 64'(ir_o), 64'd0);
    check("wirq_pend", 64'(pending_o), 64'd0);
    step(2);
    check("wirq_idle_ir", 64'(ir_o), 64'd0);
    check("wirq_idle", 64'(busy_o), 64'd0);

    // Reset mid-scan, with a tick in the reset cycle.
    cfg_write(0, 1'b1, 8'h01, 38'd30);
    do_tick(38'd30);
    step(1);
    rst_i = 1'b1; tick_i = 1'b1;
    step(1);
    rst_i = 1'b0; tick_i = 1'b0;
    model_reset();
    check("mrst_ir", 64'(ir_o), 64'd0);
    check("mrst_id", 64'(ir_id_o), 64'd0);
    check("mrst_pend", 64'(pending_o), 64'd0);
    check("mrst_en", 64'(en_o), 64'd0);
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_missed", 64'(missed_o), 64'd0);
    step(10);
    check("mrst_quiet_ir", 64'(ir_o), 64'd0);
    check("mrst_quiet_busy", 64'(busy_o), 64'd0);

    // Randomized slot configurations against the model.
    for (int it = 0; it < 40; it++) begin
      r   = {$urandom, $urandom};
      cur = r[37:0];
      for (int k = 0; k < N; k++) begin
        r  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        t  = ($urandom_range(0, 1) == 0) ? cur : (cur ^ r[37:0]);
        mk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        cfg_write(k, $urandom_range(0, 3) != 0, mk, t);
      end
      do_tick(cur);
      step(N);
      check("rnd_pend_scan", 64'(pending_o), 64'(exp_set(cur)));
      step(1);
      serve_all(exp_set(cur), 1'b1);
      check("rnd_missed", 64'(missed_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
